mem_req_arb: RTL and testbench
==============================

MEM_REQ_ARB -- requirements
Module: mem_req_arb

Interface
REQ-001 Parameters SHALL be: ADDR_BW, default 25, request address width; DATA_BW, default 32, data width; TIMEOUT_CYC, default 255, maximum cycles in WAIT before abort (range 2..65535).
REQ-002 clk_in  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_in  in  1  reset; synchronous and active-low.
REQ-004 cpu_cs  in  1  CPU request; held high until cpu_done.
REQ-005 cpu_rw  in  1  1 = write, 0 = read.
REQ-006 cpu_addr, cpu_data_wr  in  ADDR_BW / DATA_BW  CPU address and write data.
REQ-007 cpu_data_rd  out  DATA_BW  read data for the CPU.
REQ-008 cpu_done  out  1  one-cycle completion pulse to the CPU.
REQ-009 mpi_cs, mpi_rw, mpi_addr, mpi_data_wr, mpi_data_rd, mpi_done: the MPI/UART debug port, with the same widths and meanings as REQ-004..008.
REQ-010 mem_cs  out  1  one-cycle start pulse to the memory controller.
REQ-011 mem_rw, mem_addr, mem_data_wr  out  1 / ADDR_BW / DATA_BW  the latched command.
REQ-012 mem_data_rd  in  DATA_BW  controller read data; valid with mem_done.
REQ-013 mem_done  in  1  controller completion pulse.
REQ-014 arb_owner  out  1  0 = CPU, 1 = MPI; the current or last granted requester.
REQ-015 arb_timeout  out  1  one-cycle pulse when a transfer is aborted.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and RELEASE, encoded one-hot or binary.
REQ-017 IDLE: when either cs is high, the arbiter SHALL grant, latch rw/addr/data_wr of the winner into the mem_* registers, set arb_owner, and go to ISSUE.
REQ-018 Simultaneous requests SHALL be resolved by round-robin: the requester not equal to the last arb_owner wins. After reset the last owner is MPI, so the CPU wins the first tie.
REQ-019 ISSUE: mem_cs SHALL be high for exactly this one cycle, and the FSM SHALL then go to WAIT.
REQ-020 mem_rw/mem_addr/mem_data_wr SHALL stay constant from ISSUE until the FSM leaves RELEASE, regardless of requester input changes.
REQ-021 WAIT: on mem_done, the arbiter SHALL register mem_data_rd into the owner's data_rd (for reads only; unchanged on writes), pulse the owner's done next cycle, and go to RELEASE.
REQ-022 The owner's done SHALL be registered and high for exactly the RELEASE cycle. The other requester's done and data_rd SHALL be unchanged.
REQ-023 RELEASE: the arbiter SHALL return to IDLE. The owner's cs SHALL be ignored in the first IDLE cycle after RELEASE so that a late deassert is not re-granted.
REQ-024 Latency SHALL be: cs sampled at cycle N (IDLE); mem_cs at N+1; done at M+1, where M is the mem_done cycle.
REQ-025 Timeout: a counter SHALL clear on entry to WAIT and increment each WAIT cycle. On reaching TIMEOUT_CYC-1 without mem_done, the arbiter SHALL load all-ones into the owner's data_rd (for reads), pulse arb_timeout and the owner's done together, and enter RELEASE.
REQ-026 mem_done SHALL be ignored in IDLE, ISSUE and RELEASE, with no state change.
REQ-027 mem_done coinciding with the timeout cycle SHALL take precedence: normal completion, no arb_timeout.
REQ-028 A requester dropping cs during ISSUE or WAIT SHALL NOT abort the transfer; done is still pulsed.
REQ-029 No combinational path SHALL exist from any input to any output.

Reset
REQ-030 While rst_in is low at a clk_in edge, the arbiter SHALL set: FSM = IDLE; mem_cs, mem_rw, cpu_done, mpi_done and arb_timeout = 0; mem_addr, mem_data_wr, cpu_data_rd and mpi_data_rd = 0; arb_owner = 1; timeout counter = 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer silently: no done pulse, and a subsequent mem_done is ignored.
REQ-032 The first request SHALL be accepted in the first cycle rst_in is sampled high.

Verification
REQ-033 CPU read addr 0x0001234 with mem_done after 3 WAIT cycles and mem_data_rd = 0xCAFEF00D -> mem_cs is one pulse at N+1, cpu_data_rd = 0xCAFEF00D, cpu_done is one pulse, mpi_done stays 0.
REQ-034 cpu_cs and mpi_cs rise in the same cycle after reset -> CPU is served first (arb_owner = 0), then MPI (arb_owner = 1). Repeating the tie serves CPU then MPI again.
REQ-035 MPI write 0x12345678 at 0x3FFFFF (ADDR_BW = 22) while mpi_addr changes during WAIT -> mem_addr and mem_data_wr stay 0x3FFFFF / 0x12345678; mpi_data_rd is unchanged.
REQ-036 TIMEOUT_CYC = 8, no mem_done -> arb_timeout and owner done pulse together on the 8th WAIT cycle; read data = 0xFFFFFFFF. A late mem_done is ignored.
REQ-037 rst_in low during WAIT, then mem_done after release -> no done pulse, all outputs at reset values, and a new request is serviced normally.
REQ-038 cpu_cs held high for 2 cycles after cpu_done, mpi idle -> no second grant (mem_cs pulses exactly once).

Source files
------------

// File: rtl/mem_req_arb.sv
// Two-requester (CPU / MPI debug) arbiter in front of a single memory controller.
// Round-robin on ties, registered handshakes, and a WAIT-state timeout abort.
module mem_req_arb #(
  parameter int ADDR_BW     = 25,
  parameter int DATA_BW     = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               cpu_cs,
  input  logic               cpu_rw,
  input  logic [ADDR_BW-1:0] cpu_addr,
  input  logic [DATA_BW-1:0] cpu_data_wr,
  output logic [DATA_BW-1:0] cpu_data_rd,
  output logic               cpu_done,
  input  logic               mpi_cs,
  input  logic               mpi_rw,
  input  logic [ADDR_BW-1:0] mpi_addr,
  input  logic [DATA_BW-1:0] mpi_data_wr,
  output logic [DATA_BW-1:0] mpi_data_rd,
  output logic               mpi_done,
  output logic               mem_cs,
  output logic               mem_rw,
  output logic [ADDR_BW-1:0] mem_addr,
  output logic [DATA_BW-1:0] mem_data_wr,
  input  logic [DATA_BW-1:0] mem_data_rd,
  input  logic               mem_done,
  output logic               arb_owner,
  output logic               arb_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REL
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t r_state;
  state_t w_next;

  logic               r_mem_cs;
  logic               r_mem_rw;
  logic [ADDR_BW-1:0] r_mem_addr;
  logic [DATA_BW-1:0] r_mem_data_wr;
  logic [DATA_BW-1:0] r_cpu_data_rd;
  logic [DATA_BW-1:0] r_mpi_data_rd;
  logic               r_cpu_done;
  logic               r_mpi_done;
  logic               r_owner;
  logic               r_tmo;
  logic               r_skip;
  logic [15:0]        r_cnt;

  logic               w_cpu_req;
  logic               w_mpi_req;
  logic               w_grant;
  logic               w_pick_mpi;
  logic               w_tmo_hit;
  logic               w_finish;
  logic [DATA_BW-1:0] w_rd_val;
  logic               w_sel_rw;
  logic [ADDR_BW-1:0] w_sel_addr;
  logic [DATA_BW-1:0] w_sel_wr;

  // Last owner is masked for one IDLE cycle so a slow cs deassert is not re-granted.
  assign w_cpu_req  = cpu_cs & ~(r_skip & ~r_owner);
  assign w_mpi_req  = mpi_cs & ~(r_skip & r_owner);
  assign w_grant    = w_cpu_req | w_mpi_req;
  assign w_pick_mpi = w_mpi_req & (~w_cpu_req | ~r_owner);

  assign w_sel_rw   = w_pick_mpi ? mpi_rw      : cpu_rw;
  assign w_sel_addr = w_pick_mpi ? mpi_addr    : cpu_addr;
  assign w_sel_wr   = w_pick_mpi ? mpi_data_wr : cpu_data_wr;

  assign w_tmo_hit  = (r_cnt == TMO_LAST);
  assign w_finish   = mem_done | w_tmo_hit;
  assign w_rd_val   = mem_done ? mem_data_rd : '1;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_finish) w_next = S_REL;
      S_REL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_mem_cs      <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_wr <= '0;
      r_cpu_data_rd <= '0;
      r_mpi_data_rd <= '0;
      r_cpu_done    <= 1'b0;
      r_mpi_done    <= 1'b0;
      r_owner       <= 1'b1;
      r_tmo         <= 1'b0;
      r_skip        <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_mem_cs   <= 1'b0;
      r_cpu_done <= 1'b0;
      r_mpi_done <= 1'b0;
      r_tmo      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_skip <= 1'b0;
          if (w_grant) begin
            r_owner       <= w_pick_mpi;
            r_mem_rw      <= w_sel_rw;
            r_mem_addr    <= w_sel_addr;
            r_mem_data_wr <= w_sel_wr;
            r_mem_cs      <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_finish) begin
            r_tmo <= ~mem_done;
            if (r_owner) begin
              r_mpi_done <= 1'b1;
              if (!r_mem_rw) r_mpi_data_rd <= w_rd_val;
            end else begin
              r_cpu_done <= 1'b1;
              if (!r_mem_rw) r_cpu_data_rd <= w_rd_val;
            end
          end
        end
        S_REL: begin
          r_skip <= 1'b1;
        end
        default: begin
          r_skip <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_data_rd = r_cpu_data_rd;
  assign cpu_done    = r_cpu_done;
  assign mpi_data_rd = r_mpi_data_rd;
  assign mpi_done    = r_mpi_done;
  assign mem_cs      = r_mem_cs;
  assign mem_rw      = r_mem_rw;
  assign mem_addr    = r_mem_addr;
  assign mem_data_wr = r_mem_data_wr;
  assign arb_owner   = r_owner;
  assign arb_timeout = r_tmo;

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: latency, round-robin, hold, timeout,
// mid-transfer reset and late-deassert behaviour.
module tb_mem_req_arb;

  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk;
  logic          rst_in;
  logic          cpu_cs, cpu_rw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_wr, cpu_data_rd;
  logic          cpu_done;
  logic          mpi_cs, mpi_rw;
  logic [AW-1:0] mpi_addr;
  logic [DW-1:0] mpi_data_wr, mpi_data_rd;
  logic          mpi_done;
  logic          mem_cs, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_wr, mem_data_rd;
  logic          mem_done;
  logic          arb_owner, arb_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int n_memcs = 0;
  int m0;

  mem_req_arb #(
    .ADDR_BW(AW),
    .DATA_BW(DW),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .cpu_cs(cpu_cs),
    .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr),
    .cpu_data_wr(cpu_data_wr),
    .cpu_data_rd(cpu_data_rd),
    .cpu_done(cpu_done),
    .mpi_cs(mpi_cs),
    .mpi_rw(mpi_rw),
    .mpi_addr(mpi_addr),
    .mpi_data_wr(mpi_data_wr),
    .mpi_data_rd(mpi_data_rd),
    .mpi_done(mpi_done),
    .mem_cs(mem_cs),
    .mem_rw(mem_rw),
    .mem_addr(mem_addr),
    .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd),
    .mem_done(mem_done),
    .arb_owner(arb_owner),
    .arb_timeout(arb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_cs === 1'b1) n_memcs++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic finish_wait(input int nw, input logic [DW-1:0] d);
    repeat (nw - 1) tick();
    mem_done    = 1'b1;
    mem_data_rd = d;
    tick();
    mem_done    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_memcs"}, 64'(mem_cs), 64'd0);
    chk({tag, "_memrw"}, 64'(mem_rw), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdat"}, 64'(mem_data_wr), 64'd0);
    chk({tag, "_cpurd"}, 64'(cpu_data_rd), 64'd0);
    chk({tag, "_mpird"}, 64'(mpi_data_rd), 64'd0);
    chk({tag, "_cpudn"}, 64'(cpu_done), 64'd0);
    chk({tag, "_mpidn"}, 64'(mpi_done), 64'd0);
    chk({tag, "_owner"}, 64'(arb_owner), 64'd1);
    chk({tag, "_tmo"}, 64'(arb_timeout), 64'd0);
  endtask

  initial begin
    rst_in = 0; cpu_cs = 0; cpu_rw = 0; cpu_addr = '0; cpu_data_wr = '0;
    mpi_cs = 0; mpi_rw = 0; mpi_addr = '0; mpi_data_wr = '0;
    mem_data_rd = '0; mem_done = 0;
    repeat (3) tick();
    chk_reset_vals("rst");

    // CPU read, mem_done after 3 WAIT cycles, first cycle out of reset
    m0 = n_memcs;
    rst_in = 1; cpu_cs = 1; cpu_rw = 0; cpu_addr = 22'h001234;
    tick();
    chk("t1_memcs_n1", 64'(mem_cs), 64'd1);
    chk("t1_owner", 64'(arb_owner), 64'd0);
    chk("t1_addr", 64'(mem_addr), 64'h1234);
    chk("t1_rw", 64'(mem_rw), 64'd0);
    tick();
    chk("t1_memcs_n2", 64'(mem_cs), 64'd0);
    finish_wait(4, 32'hCAFEF00D);
    chk("t1_cpudone", 64'(cpu_done), 64'd1);
    chk("t1_cpurd", 64'(cpu_data_rd), 64'hCAFEF00D);
    chk("t1_mpidone", 64'(mpi_done), 64'd0);
    chk("t1_tmo", 64'(arb_timeout), 64'd0);
    cpu_cs = 0;
    tick();
    chk("t1_done_off", 64'(cpu_done), 64'd0);
    tick();
    chk("t1_memcs_cnt", 64'(n_memcs - m0), 64'd1);
    chk("t1_mpird", 64'(mpi_data_rd), 64'd0);

    // Tie right after reset: CPU first, then MPI, then repeat
    rst_in = 0;
    tick(); tick();
    rst_in = 1; cpu_cs = 1; mpi_cs = 1; cpu_rw = 0; mpi_rw = 0;
    cpu_addr = 22'h000100; mpi_addr = 22'h000200;
    tick();
    chk("t2_own_a", 64'(arb_owner), 64'd0);
    chk("t2_addr_a", 64'(mem_addr), 64'h100);
    tick();
    finish_wait(1, 32'h11111111);
    chk("t2_cpudn_a", 64'(cpu_done), 64'd1);
    chk("t2_mpidn_a", 64'(mpi_done), 64'd0);
    cpu_cs = 0;
    tick();
    chk("t2_idle_cs", 64'(mem_cs), 64'd0);
    tick();
    chk("t2_own_b", 64'(arb_owner), 64'd1);
    chk("t2_cs_b", 64'(mem_cs), 64'd1);
    chk("t2_addr_b", 64'(mem_addr), 64'h200);
    tick();
    finish_wait(1, 32'h22222222);
    chk("t2_mpidn_b", 64'(mpi_done), 64'd1);
    chk("t2_mpird_b", 64'(mpi_data_rd), 64'h22222222);
    chk("t2_cpurd_b", 64'(cpu_data_rd), 64'h11111111);
    chk("t2_cpudn_b", 64'(cpu_done), 64'd0);
    mpi_cs = 0;
    tick(); tick();
    cpu_cs = 1; mpi_cs = 1;
    tick();
    chk("t2_own_c", 64'(arb_owner), 64'd0);
    tick();
    finish_wait(2, 32'h33333333);
    chk("t2_cpurd_c", 64'(cpu_data_rd), 64'h33333333);
    cpu_cs = 0;
    tick(); tick();
    chk("t2_own_d", 64'(arb_owner), 64'd1);
    tick();
    finish_wait(2, 32'h44444444);
    chk("t2_mpird_d", 64'(mpi_data_rd), 64'h44444444);
    chk("t2_mpidn_d", 64'(mpi_done), 64'd1);
    mpi_cs = 0;
    tick(); tick();

    // MPI write, requester inputs change during WAIT
    mpi_cs = 1; mpi_rw = 1; mpi_addr = 22'h3FFFFF; mpi_data_wr = 32'h12345678;
    tick();
    chk("t3_rw", 64'(mem_rw), 64'd1);
    chk("t3_addr_i", 64'(mem_addr), 64'h3FFFFF);
    chk("t3_wd_i", 64'(mem_data_wr), 64'h12345678);
    mpi_addr = 22'h000AAA; mpi_data_wr = 32'h0; mpi_rw = 0;
    tick();
    mpi_cs = 0;
    chk("t3_addr_w1", 64'(mem_addr), 64'h3FFFFF);
    tick();
    chk("t3_wd_w2", 64'(mem_data_wr), 64'h12345678);
    chk("t3_rw_w2", 64'(mem_rw), 64'd1);
    mem_done = 1; mem_data_rd = 32'hDEADBEEF;
    tick();
    mem_done = 0;
    chk("t3_mpidn", 64'(mpi_done), 64'd1);
    chk("t3_mpird", 64'(mpi_data_rd), 64'h44444444);
    chk("t3_addr_rel", 64'(mem_addr), 64'h3FFFFF);
    tick(); tick();

    // Timeout with no mem_done, then a late mem_done
    cpu_cs = 1; cpu_rw = 0; cpu_addr = 22'h000055;
    tick();
    tick();
    repeat (6) tick();
    chk("t4_w7_tmo", 64'(arb_timeout), 64'd0);
    tick();
    chk("t4_w8_tmo", 64'(arb_timeout), 64'd0);
    chk("t4_w8_dn", 64'(cpu_done), 64'd0);
    tick();
    chk("t4_tmo", 64'(arb_timeout), 64'd1);
    chk("t4_cpudn", 64'(cpu_done), 64'd1);
    chk("t4_cpurd", 64'(cpu_data_rd), 64'hFFFFFFFF);
    chk("t4_mpidn", 64'(mpi_done), 64'd0);
    cpu_cs = 0; mem_done = 1; mem_data_rd = 32'h01010101;
    tick();
    chk("t4_tmo_off", 64'(arb_timeout), 64'd0);
    chk("t4_dn_off", 64'(cpu_done), 64'd0);
    tick();
    mem_done = 0;
    chk("t4_late_cs", 64'(mem_cs), 64'd0);
    chk("t4_late_rd", 64'(cpu_data_rd), 64'hFFFFFFFF);
    tick();

    // mem_done on the timeout cycle completes normally
    cpu_cs = 1; cpu_rw = 0; cpu_addr = 22'h000066;
    tick();
    tick();
    finish_wait(8, 32'h0BADCAFE);
    chk("t5_tmo", 64'(arb_timeout), 64'd0);
    chk("t5_cpudn", 64'(cpu_done), 64'd1);
    chk("t5_cpurd", 64'(cpu_data_rd), 64'h0BADCAFE);
    cpu_cs = 0;
    tick(); tick();

    // Reset during WAIT, then a stray mem_done
    mpi_cs = 1; mpi_rw = 0; mpi_addr = 22'h000077;
    tick();
    tick();
    tick();
    rst_in = 0;
    tick();
    chk_reset_vals("t6rst");
    mpi_cs = 0; rst_in = 1; mem_done = 1; mem_data_rd = 32'h5A5A5A5A;
    tick();
    mem_done = 0;
    chk("t6_mpidn", 64'(mpi_done), 64'd0);
    chk("t6_cpudn", 64'(cpu_done), 64'd0);
    chk("t6_memcs", 64'(mem_cs), 64'd0);
    chk("t6_mpird", 64'(mpi_data_rd), 64'd0);
    tick();

    // New CPU write after reset; cs held through done and one more cycle
    m0 = n_memcs;
    cpu_cs = 1; cpu_rw = 1; cpu_addr = 22'h000042; cpu_data_wr = 32'hA5A5A5A5;
    tick();
    chk("t7_cs", 64'(mem_cs), 64'd1);
    chk("t7_own", 64'(arb_owner), 64'd0);
    chk("t7_wd", 64'(mem_data_wr), 64'hA5A5A5A5);
    tick();
    finish_wait(2, 32'h99999999);
    chk("t7_cpudn", 64'(cpu_done), 64'd1);
    chk("t7_cpurd", 64'(cpu_data_rd), 64'd0);
    tick();
    chk("t7_idle1", 64'(mem_cs), 64'd0);
    cpu_cs = 0;
    tick();
    chk("t7_idle2", 64'(mem_cs), 64'd0);
    mem_done = 1;
    tick();
    mem_done = 0;
    chk("t7_idle3", 64'(mem_cs), 64'd0);
    chk("t7_idle_dn", 64'(cpu_done), 64'd0);
    tick();
    chk("t7_memcs_cnt", 64'(n_memcs - m0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
